// File: rtl/cmd_tag_pool_pkg.sv
// Shared types for the CAPI command-tag pool: FSM states, tag line, free-list status,
// error bit positions and the tag parity helper.
package cmd_tag_pool_pkg;

   typedef enum logic [1:0] {
      TAG_BUFFER_RESET = 2'd0,
      TAG_BUFFER_INIT  = 2'd1,
      TAG_BUFFER_POP   = 2'd2,
      TAG_BUFFER_READY = 2'd3
   } tag_buffer_state;

   typedef struct packed {
      logic [12:0] command;
      logic [7:0]  cu_id;
      logic [63:0] address;
      logic [7:0]  tag;
   } CommandTagLine;

   typedef struct packed {
      logic full;
      logic alfull;
      logic valid;
      logic empty;
   } BufferStatus;

   localparam int TAG_POOL_ERR_RANGE  = 0;
   localparam int TAG_POOL_ERR_DOUBLE = 1;

   // Odd parity: the tag plus this bit always carries an odd number of ones.
   function automatic logic tag_odd_parity(input logic [7:0] tag);
      return ~^tag;
   endfunction

endpackage

// File: rtl/cmd_tag_pool_if.sv
// Alloc/release handshake between the command arbiter, response control and the tag pool.
interface cmd_tag_pool_if;

   logic                                  alloc_req;
   cmd_tag_pool_pkg::CommandTagLine       alloc_cmd_in;
   logic                                  alloc_gnt;
   cmd_tag_pool_pkg::CommandTagLine       alloc_cmd_out;
   logic                                  alloc_tag_par;
   logic                                  release_valid;
   logic [7:0]                            release_tag;
   cmd_tag_pool_pkg::CommandTagLine       release_cmd_out;
   logic                                  release_out_vld;

   modport master (
      output alloc_req, alloc_cmd_in, release_valid, release_tag,
      input  alloc_gnt, alloc_cmd_out, alloc_tag_par, release_cmd_out, release_out_vld
   );

   modport slave (
      input  alloc_req, alloc_cmd_in, release_valid, release_tag,
      output alloc_gnt, alloc_cmd_out, alloc_tag_par, release_cmd_out, release_out_vld
   );

endinterface

// File: rtl/cmd_tag_pool_free_fifo.sv
// Circular free-tag list: NUM_TAGS entries of 8-bit tags, synchronous clear, registered count.
module tag_free_fifo #(
   parameter  int NUM_TAGS = 32,
   localparam int TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             clear,
   input  logic             push,
   input  logic [7:0]       push_tag,
   input  logic             pop,
   output logic [7:0]       pop_tag,
   output logic [TAG_W:0]   free_count
);

   logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [TAG_W:0]   count_q, count_d;
   logic [7:0]       mem_q [NUM_TAGS];
   logic             mem_we;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_we   = 1'b0;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we = push;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read before the count says it was written.
   always_ff @(posedge clock) begin
      if (mem_we) mem_q[wr_ptr_q] <= push_tag;
   end

   assign pop_tag    = mem_q[rd_ptr_q];
   assign free_count = count_q;

endmodule

// File: rtl/cmd_tag_pool.sv
// CAPI command-tag allocator: hands out free PSL tags, keeps each tag's CommandTagLine,
// returns it on release, flags illegal/double releases and restarts cleanly on flush.
//
//   state            | meaning
//   -----------------+-----------------------------------------------------------
//   TAG_BUFFER_RESET | pool idle and cleared, waits for enabled_in
//   TAG_BUFFER_INIT  | pushes tags 0..NUM_TAGS-1 into the free list, one per cycle
//   TAG_BUFFER_POP   | unused encoding, falls back to RESET
//   TAG_BUFFER_READY | serving alloc and release traffic
module cmd_tag_pool
   import cmd_tag_pool_pkg::*;
#(
   parameter  int NUM_TAGS  = 32,
   parameter  int LOW_WATER = 4,
   localparam int TAG_W     = $clog2(NUM_TAGS)
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             enabled_in,
   input  logic             flush_in,
   cmd_tag_pool_if.slave    tag_if,
   output BufferStatus      status_out,
   output logic [TAG_W:0]   outstanding_out,
   output logic [1:0]       error_out,
   output logic             ready_out
);

   localparam logic [TAG_W-1:0] INIT_MAX    = TAG_W'(NUM_TAGS - 1);
   localparam logic [TAG_W:0]   FULL_CNT    = NUM_TAGS[TAG_W:0];
   localparam logic [TAG_W:0]   LOW_WATER_W = LOW_WATER[TAG_W:0];
   localparam logic [8:0]       TAG_LIMIT   = NUM_TAGS[8:0];

   tag_buffer_state  state_q, state_d;
   logic [TAG_W-1:0] init_cnt_q, init_cnt_d;
   logic [NUM_TAGS-1:0] bitmap_q, bitmap_d;
   logic [TAG_W:0]   outstanding_q, outstanding_d;
   logic [1:0]       error_q, error_d;
   logic             alloc_gnt_q, alloc_gnt_d;
   CommandTagLine    alloc_cmd_q, alloc_cmd_d;
   logic             alloc_par_q, alloc_par_d;
   logic             release_vld_q, release_vld_d;
   CommandTagLine    release_cmd_q, release_cmd_d;
   CommandTagLine    meta_q [NUM_TAGS];

   logic             fifo_clear;
   logic             init_push;
   logic [7:0]       init_tag;
   logic             fifo_push;
   logic [7:0]       fifo_push_tag;
   logic             fifo_pop;
   logic [7:0]       fifo_pop_tag;
   logic [TAG_W:0]   free_count;
   logic             active;
   logic             rel_req;
   logic             rel_in_range;
   logic             rel_legal;
   logic             err_range;
   logic             err_double;
   logic [TAG_W-1:0] rel_idx;
   logic [TAG_W-1:0] alloc_idx;
   CommandTagLine    grant_line;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      fifo_clear = 1'b0;
      init_push  = 1'b0;
      if (!enabled_in) begin
         state_d    = TAG_BUFFER_RESET;
         fifo_clear = 1'b1;
      end else begin
         case (state_q)
            TAG_BUFFER_RESET: begin
               fifo_clear = 1'b1;
               state_d    = TAG_BUFFER_INIT;
               init_cnt_d = INIT_MAX;
            end
            TAG_BUFFER_INIT: begin
               init_push = 1'b1;
               if (init_cnt_q == '0) state_d = TAG_BUFFER_READY;
               else                  init_cnt_d = init_cnt_q - 1'b1;
            end
            TAG_BUFFER_READY: begin
               if (flush_in) begin
                  fifo_clear = 1'b1;
                  state_d    = TAG_BUFFER_INIT;
                  init_cnt_d = INIT_MAX;
               end
            end
            default: begin
               fifo_clear = 1'b1;
               state_d    = TAG_BUFFER_RESET;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q    <= TAG_BUFFER_RESET;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // The down-counter runs INIT_MAX..0, so tags enter the free list in ascending order.
   assign init_tag = 8'(INIT_MAX - init_cnt_q);

   // Flush takes priority over same-cycle traffic: nothing moves unless READY is undisturbed.
   assign active       = enabled_in && (state_q == TAG_BUFFER_READY) && !flush_in;
   assign rel_req      = active && tag_if.release_valid;
   assign rel_in_range = {1'b0, tag_if.release_tag} < TAG_LIMIT;
   assign rel_idx      = tag_if.release_tag[TAG_W-1:0];
   assign rel_legal    = rel_req && rel_in_range && bitmap_q[rel_idx];
   assign err_range    = rel_req && !rel_in_range;
   assign err_double   = rel_req && rel_in_range && !bitmap_q[rel_idx];

   assign fifo_pop      = active && tag_if.alloc_req && (free_count != '0);
   assign fifo_push     = init_push || rel_legal;
   assign fifo_push_tag = init_push ? init_tag : tag_if.release_tag;
   assign alloc_idx     = fifo_pop_tag[TAG_W-1:0];

   always_comb begin
      grant_line     = tag_if.alloc_cmd_in;
      grant_line.tag = fifo_pop_tag;
   end

   tag_free_fifo #(.NUM_TAGS(NUM_TAGS)) u_free_fifo (
      .clock      (clock),
      .rstn       (rstn),
      .clear      (fifo_clear),
      .push       (fifo_push),
      .push_tag   (fifo_push_tag),
      .pop        (fifo_pop),
      .pop_tag    (fifo_pop_tag),
      .free_count (free_count)
   );

   always_comb begin
      bitmap_d      = bitmap_q;
      outstanding_d = outstanding_q;
      error_d       = error_q;
      alloc_gnt_d   = fifo_pop;
      alloc_cmd_d   = alloc_cmd_q;
      alloc_par_d   = alloc_par_q;
      release_vld_d = rel_legal;
      release_cmd_d = release_cmd_q;

      error_d[TAG_POOL_ERR_RANGE]  = error_q[TAG_POOL_ERR_RANGE]  | err_range;
      error_d[TAG_POOL_ERR_DOUBLE] = error_q[TAG_POOL_ERR_DOUBLE] | err_double;

      if (fifo_clear) begin
         bitmap_d      = '0;
         outstanding_d = '0;
      end else begin
         if (fifo_pop)  bitmap_d[alloc_idx] = 1'b1;
         if (rel_legal) bitmap_d[rel_idx]   = 1'b0;
         case ({fifo_pop, rel_legal})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
         endcase
      end

      if (fifo_pop) begin
         alloc_cmd_d = grant_line;
         alloc_par_d = tag_odd_parity(fifo_pop_tag);
      end
      if (rel_legal) release_cmd_d = meta_q[rel_idx];
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         bitmap_q      <= '0;
         outstanding_q <= '0;
         error_q       <= '0;
         alloc_gnt_q   <= 1'b0;
         alloc_cmd_q   <= '0;
         alloc_par_q   <= 1'b0;
         release_vld_q <= 1'b0;
         release_cmd_q <= '0;
      end else begin
         bitmap_q      <= bitmap_d;
         outstanding_q <= outstanding_d;
         error_q       <= error_d;
         alloc_gnt_q   <= alloc_gnt_d;
         alloc_cmd_q   <= alloc_cmd_d;
         alloc_par_q   <= alloc_par_d;
         release_vld_q <= release_vld_d;
         release_cmd_q <= release_cmd_d;
      end
   end

   // A tag is never released and re-granted in one cycle, so one write and one read port suffice.
   always_ff @(posedge clock) begin
      if (fifo_pop) meta_q[alloc_idx] <= grant_line;
   end

   always_comb begin
      status_out = '0;
      if (state_q != TAG_BUFFER_RESET) begin
         status_out.empty  = (free_count == '0);
         status_out.full   = (free_count == FULL_CNT);
         status_out.alfull = (free_count <= LOW_WATER_W);
         status_out.valid  = (free_count != '0);
      end
   end

   assign ready_out               = (state_q == TAG_BUFFER_READY);
   assign outstanding_out         = outstanding_q;
   assign error_out               = error_q;
   assign tag_if.alloc_gnt        = alloc_gnt_q;
   assign tag_if.alloc_cmd_out    = alloc_cmd_q;
   assign tag_if.alloc_tag_par    = alloc_par_q;
   assign tag_if.release_out_vld  = release_vld_q;
   assign tag_if.release_cmd_out  = release_cmd_q;

endmodule

// File: tb/tb_cmd_tag_pool.sv
// Self-checking bench for cmd_tag_pool (32 tags, low water 4): vector table plus
// hand-written init, flush, enable and reset sequences, expectations via a queue.
module tb_cmd_tag_pool;
   import cmd_tag_pool_pkg::*;

   localparam int NT = 32;
   localparam int LW = 4;

   logic        clock = 1'b0;
   logic        rstn = 1'b0;
   logic        enabled_in = 1'b0;
   logic        flush_in = 1'b0;
   BufferStatus status_out;
   logic [5:0]  outstanding_out;
   logic [1:0]  error_out;
   logic        ready_out;

   cmd_tag_pool_if tag_if();

   cmd_tag_pool #(.NUM_TAGS(NT), .LOW_WATER(LW)) dut (
      .clock           (clock),
      .rstn            (rstn),
      .enabled_in      (enabled_in),
      .flush_in        (flush_in),
      .tag_if          (tag_if.slave),
      .status_out      (status_out),
      .outstanding_out (outstanding_out),
      .error_out       (error_out),
      .ready_out       (ready_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       areq;
      logic [7:0] acu;
      logic       rvld;
      logic [7:0] rtag;
      logic       flush;
      logic       gnt;
      logic [7:0] tag;
      logic       rout;
      logic [7:0] rcu;
      logic [1:0] err;
      int         outst;
   } vec_t;

   typedef struct {
      logic          gnt;
      CommandTagLine acmd;
      logic          rout;
      logic [7:0]    rcu;
      logic [7:0]    rtag;
      logic [1:0]    err;
      int            outst;
      logic          flush;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic BufferStatus exp_status(input int free);
      BufferStatus s;
      s.full   = (free == NT);
      s.alfull = (free <= LW);
      s.valid  = (free != 0);
      s.empty  = (free == 0);
      return s;
   endfunction

   function automatic CommandTagLine mk_cmd(input logic [7:0] cu);
      CommandTagLine c;
      c.command = 13'h0A5B;
      c.cu_id   = cu;
      c.address = {32'hDEAD_0000, 24'h0, cu};
      c.tag     = 8'hFF;
      return c;
   endfunction

   task automatic idle_inputs();
      tag_if.alloc_req     = 1'b0;
      tag_if.alloc_cmd_in  = '0;
      tag_if.release_valid = 1'b0;
      tag_if.release_tag   = 8'h00;
      flush_in             = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      exp_t got;
      @(negedge clock);
      tag_if.alloc_req     = v.areq;
      tag_if.alloc_cmd_in  = mk_cmd(v.acu);
      tag_if.release_valid = v.rvld;
      tag_if.release_tag   = v.rtag;
      flush_in             = v.flush;
      e.gnt      = v.gnt;
      e.acmd     = mk_cmd(v.acu);
      e.acmd.tag = v.tag;
      e.rout     = v.rout;
      e.rcu      = v.rcu;
      e.rtag     = v.rtag;
      e.err      = v.err;
      e.outst    = v.outst;
      e.flush    = v.flush;
      sb.push_back(e);
      @(posedge clock);
      #1;
      idle_inputs();
      got = sb.pop_front();
      check("alloc_gnt", tag_if.alloc_gnt, got.gnt);
      if (got.gnt) begin
         check("alloc_cmd_out", tag_if.alloc_cmd_out, got.acmd);
         check("alloc_tag_par", tag_if.alloc_tag_par, ~^got.acmd.tag);
      end
      check("release_out_vld", tag_if.release_out_vld, got.rout);
      if (got.rout) begin
         check("release_cu_id", tag_if.release_cmd_out.cu_id, got.rcu);
         check("release_tag_field", tag_if.release_cmd_out.tag, got.rtag);
      end
      check("error_out", error_out, got.err);
      check("outstanding", outstanding_out, got.outst);
      if (got.flush) check("ready_after_flush", ready_out, 1'b0);
      else           check("status", status_out, exp_status(NT - got.outst));
   endtask

   task automatic wait_ready(input string name, input int exp_cycles);
      int n = 0;
      while (!ready_out && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      check(name, n, exp_cycles);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      vec_t v;

      // tag 5 was granted with cu_id 5^6 = 3, tag 9 with 9^6 = 15
      tbl[0] = '{1'b0, 8'h00, 1'b1, 8'd5,  1'b0, 1'b0, 8'd0, 1'b1, 8'h03, 2'b00, 31};
      tbl[1] = '{1'b1, 8'hA5, 1'b0, 8'd0,  1'b0, 1'b1, 8'd5, 1'b0, 8'h00, 2'b00, 32};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 8'd5,  1'b0, 1'b0, 8'd0, 1'b1, 8'hA5, 2'b00, 31};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 8'd5,  1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 2'b10, 31};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 8'd40, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 2'b11, 31};
      tbl[5] = '{1'b1, 8'h11, 1'b0, 8'd0,  1'b0, 1'b1, 8'd5, 1'b0, 8'h00, 2'b11, 32};
      tbl[6] = '{1'b1, 8'h22, 1'b1, 8'd9,  1'b0, 1'b0, 8'd0, 1'b1, 8'h0F, 2'b11, 31};
      tbl[7] = '{1'b1, 8'h3C, 1'b0, 8'd0,  1'b0, 1'b1, 8'd9, 1'b0, 8'h00, 2'b11, 32};
      tbl[8] = '{1'b1, 8'h44, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 2'b11, 32};

      idle_inputs();
      enabled_in = 1'b1;
      #12;
      check("rst_ready", ready_out, 1'b0);
      check("rst_status", status_out, 4'b0000);
      check("rst_outstanding", outstanding_out, 6'd0);
      check("rst_error", error_out, 2'b00);
      check("rst_gnt", tag_if.alloc_gnt, 1'b0);
      check("rst_rel_vld", tag_if.release_out_vld, 1'b0);

      @(negedge clock);
      rstn = 1'b1;
      wait_ready("init_cycles", 33);
      check("init_status", status_out, exp_status(NT));
      check("init_outstanding", outstanding_out, 6'd0);

      for (int i = 0; i < 34; i++) begin
         v = '{1'b1, 8'(i ^ 6), 1'b0, 8'd0, 1'b0,
               (i < NT), 8'(i), 1'b0, 8'h00, 2'b00, (i < NT) ? i + 1 : NT};
         apply(v);
      end

      for (int i = 0; i < 9; i++) apply(tbl[i]);

      for (int t = 10; t < 32; t++) begin
         v = '{1'b0, 8'h00, 1'b1, 8'(t), 1'b0,
               1'b0, 8'd0, 1'b1, 8'(t ^ 6), 2'b11, 31 - (t - 10)};
         apply(v);
      end

      // grant from a non-empty pool while releasing another tag
      apply('{1'b1, 8'h77, 1'b1, 8'd0, 1'b0, 1'b1, 8'd10, 1'b1, 8'h06, 2'b11, 10});

      // flush wins over same-cycle alloc and release
      apply('{1'b1, 8'h55, 1'b1, 8'd1, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 2'b11, 0});
      wait_ready("flush_cycles", 32);
      check("flush_status", status_out, exp_status(NT));
      check("flush_outstanding", outstanding_out, 6'd0);
      check("flush_error_kept", error_out, 2'b11);
      apply('{1'b1, 8'h66, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 2'b11, 1});

      @(negedge clock);
      enabled_in = 1'b0;
      @(posedge clock);
      #1;
      check("disable_ready", ready_out, 1'b0);
      check("disable_status", status_out, 4'b0000);
      check("disable_outstanding", outstanding_out, 6'd0);
      @(negedge clock);
      enabled_in = 1'b1;
      wait_ready("reenable_cycles", 33);

      apply('{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 2'b11, 0});
      repeat (5) @(posedge clock);
      #2;
      rstn = 1'b0;
      #1;
      check("midinit_ready", ready_out, 1'b0);
      check("midinit_status", status_out, 4'b0000);
      check("midinit_error", error_out, 2'b00);
      check("midinit_outstanding", outstanding_out, 6'd0);
      check("midinit_alloc_cmd", tag_if.alloc_cmd_out, '0);
      check("midinit_release_cmd", tag_if.release_cmd_out, '0);
      @(negedge clock);
      rstn = 1'b1;
      wait_ready("reinit_cycles", 33);
      check("reinit_status", status_out, exp_status(NT));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
